// File: rtl/alu_mult_sequencer_pkg.sv
// Shared definitions for the execute-stage ALU and the multi-cycle multiplier
// sequencer: ALU operation codes, sequencer FSM state encoding and the
// iteration limit of the shift-add loop.
package alu_mult_sequencer_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  // ALU operation codes as decoded by the ALU control unit
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Counter value of the final shift-add iteration
  localparam logic [5:0] LAST_ITER = 6'd31;

  // Carry out of an unsigned add, recovered from the wrapped sum
  function automatic logic add_carry(input logic [ALU_WIDTH-1:0] sum,
                                     input logic [ALU_WIDTH-1:0] addend);
    return (sum < addend);
  endfunction

endpackage

// File: rtl/alu_mult_sequencer_alu.sv
// Execute-stage 32-bit ALU. Purely combinational.
// Ports:
//   alu_operation  in   4   operation code (see package)
//   a, b           in   W   operands
//   shamt          in   5   shift amount for SLL/SRL
//   result         out  W   operation result
module alu_mult_sequencer_alu
  import alu_mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_operation)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier that borrows an ALU
// instance (fixed at ADD) for every partial-product addition. The pipeline
// stalls while busy is high.
// Ports:
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous, active-high reset
//   start         in   1   request, sampled only when idle
//   multiplicand  in   W   operand A, latched on an accepted start
//   multiplier    in   W   operand B, latched on an accepted start
//   busy          out  1   high while computing and during the done cycle
//   done          out  1   one-cycle pulse, product valid
//   product_hi    out  W   upper half of the product
//   product_lo    out  W   lower half of the product
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter bit          ZERO_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  seq_state_e       state, state_next;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             accept;
  logic             bypass;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  alu_mult_sequencer_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .alu_operation(ALU_ADD),
    .a            (hi),
    .b            (mcand),
    .shamt        (5'd0),
    .result       (sum)
  );

  assign carry = add_carry(sum, hi);

  // One shift-add step: conditionally add, then shift the 65-bit
  // {carry,hi,lo} right by one so the carry lands in bit 63.
  always_comb begin
    iter_hi = '0;
    iter_lo = '0;
    if (lo[0]) begin
      {iter_hi, iter_lo} = {carry, sum, lo[WIDTH-1:1]};
    end else begin
      {iter_hi, iter_lo} = {1'b0, hi, lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bypass     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (ZERO_BYPASS && ((multiplicand == '0) || (multiplier == '0))) begin
            bypass     = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mcand <= multiplicand;
      hi    <= '0;
      lo    <= bypass ? '0 : multiplier;
    end else if (state == ST_CALC) begin
      cnt <= cnt + 6'd1;
      hi  <= iter_hi;
      lo  <= iter_lo;
    end
  end

  assign product_hi = hi;
  assign product_lo = lo;

endmodule
